// File: rtl/iecdrv_sd_arbiter_if.sv
// rtl/iecdrv_sd_arbiter_if.sv - drive-side and host-side SD block signals shared by the arbiter
interface iecdrv_sd_arbiter_if #(
  parameter int NUM = 4
);
  // drive side
  logic [NUM*32-1:0] req_lba;
  logic [NUM-1:0]    req_rd;
  logic [NUM-1:0]    req_wr;
  logic [NUM-1:0]    req_ack;
  logic [NUM-1:0]    req_buff_wr;
  logic [NUM*8-1:0]  req_buff_din;
  logic [NUM-1:0]    req_err;
  // host side
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic              busy;

  // the arbiter itself
  modport slave (
    input  req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
    output req_ack, req_buff_wr, req_err, sd_lba, sd_rd, sd_wr, sd_buff_din, busy
  );

  // the surrounding system (drives plus host)
  modport master (
    output req_lba, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
    input  req_ack, req_buff_wr, req_err, sd_lba, sd_rd, sd_wr, sd_buff_din, busy
  );
endinterface

// File: rtl/iecdrv_sd_arbiter.sv
// rtl/iecdrv_sd_arbiter.sv - round-robin sharing of one host SD block port among NUM drives
module iecdrv_sd_arbiter #(
  parameter int          NUM     = 4,
  parameter logic [23:0] TIMEOUT = 24'd16000000
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  iecdrv_sd_arbiter_if.slave bus
);

  localparam int GW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr_ptr;
  logic [23:0]     r_cnt;
  logic [31:0]     r_sd_lba;
  logic            r_sd_rd;
  logic            r_sd_wr;
  logic [NUM-1:0]  r_err;

  state_t          w_state_nxt;
  logic [GW-1:0]   w_grant_nxt;
  logic [GW-1:0]   w_rr_nxt;
  logic [23:0]     w_cnt_nxt;
  logic [31:0]     w_lba_nxt;
  logic            w_rd_nxt;
  logic            w_wr_nxt;
  logic [NUM-1:0]  w_err_nxt;

  logic [NUM-1:0]  w_pend;
  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic [GW:0]     w_sum;
  logic [GW-1:0]   w_grant_inc;
  logic            w_busy;

  assign w_pend      = bus.req_rd | bus.req_wr;
  assign w_busy      = (r_state != S_IDLE);
  // rotation pointer after a finished or aborted request; wraps to drive 0
  assign w_grant_inc = (r_grant == GW'(NUM - 1)) ? '0 : r_grant + 1'b1;

  // scan pending drives starting at the rotation pointer, first hit wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(NUM)) begin
        w_sum = w_sum - (GW+1)'(NUM);
      end
      if (!w_found && w_pend[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[GW-1:0];
      end
    end
  end

  // next-state logic: one outstanding sector request, abort on withdraw or ack timeout
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_cnt;
    w_lba_nxt   = r_sd_lba;
    w_rd_nxt    = r_sd_rd;
    w_wr_nxt    = r_sd_wr;
    w_err_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_lba_nxt   = bus.req_lba[{w_pick, 5'b00000} +: 32];
          // read wins when a drive raises both
          w_rd_nxt    = bus.req_rd[w_pick];
          w_wr_nxt    = !bus.req_rd[w_pick] && bus.req_wr[w_pick];
          w_cnt_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.sd_ack) begin
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_state_nxt = S_XFER;
        end else if (!w_pend[r_grant]) begin
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_rr_nxt    = w_grant_inc;
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT != 24'd0) && (r_cnt == TIMEOUT - 24'd1)) begin
          w_err_nxt   = NUM'(1) << r_grant;
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_rr_nxt    = w_grant_inc;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + 24'd1;
        end
      end
      S_XFER: begin
        // idle for one cycle after ack falls before arbitrating again
        if (!bus.sd_ack) begin
          w_rr_nxt    = w_grant_inc;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state and host request registers; async reset releases any grant immediately
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_sd_lba <= '0;
      r_sd_rd  <= 1'b0;
      r_sd_wr  <= 1'b0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sd_lba <= w_lba_nxt;
      r_sd_rd  <= w_rd_nxt;
      r_sd_wr  <= w_wr_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // zero-latency routing of ack and buffer strobes so they stay aligned with sd_buff_addr
  always_comb begin
    bus.req_ack     = '0;
    bus.req_buff_wr = '0;
    for (int i = 0; i < NUM; i++) begin
      bus.req_ack[i]     = bus.sd_ack && w_busy && (r_grant == GW'(i));
      bus.req_buff_wr[i] = bus.sd_buff_wr && ((r_state == S_XFER) || (r_state == S_REQ)) &&
                           (r_grant == GW'(i));
    end
  end

  assign bus.sd_buff_din = w_busy ? bus.req_buff_din[{r_grant, 3'b000} +: 8] : 8'hFF;
  assign bus.sd_lba      = r_sd_lba;
  assign bus.sd_rd       = r_sd_rd;
  assign bus.sd_wr       = r_sd_wr;
  assign bus.req_err     = r_err;
  assign bus.busy        = w_busy;

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// tb/tb_iecdrv_sd_arbiter.sv - self-checking bench for iecdrv_sd_arbiter
module tb_iecdrv_sd_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  iecdrv_sd_arbiter_if #(.NUM(4)) bus ();

  iecdrv_sd_arbiter #(.NUM(4), .TIMEOUT(24'd100)) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lba(input int i, input logic [31:0] v);
    bus.req_lba[i*32 +: 32] = v;
  endtask

  task automatic set_din(input int i, input logic [7:0] v);
    bus.req_buff_din[i*8 +: 8] = v;
  endtask

  task automatic clear_inputs();
    bus.req_lba      = '0;
    bus.req_rd       = '0;
    bus.req_wr       = '0;
    bus.req_buff_din = '0;
    bus.sd_ack       = 1'b0;
    bus.sd_buff_wr   = 1'b0;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rr_exp [6];
    int          w;
    int          m_ptr;
    int          e;
    logic [31:0] m_lba [4];
    logic [7:0]  m_din [4];
    logic [3:0]  rdv, wrv, pend;

    rr_exp = '{0, 1, 3, 0, 1, 3};

    // reset state, including ack/strobe held during reset
    clear_inputs();
    bus.sd_ack     = 1'b1;
    bus.sd_buff_wr = 1'b1;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_sd_rd", bus.sd_rd, 0);
    chk("rst_sd_wr", bus.sd_wr, 0);
    chk("rst_sd_lba", bus.sd_lba, 0);
    chk("rst_req_err", bus.req_err, 0);
    chk("rst_req_ack", bus.req_ack, 0);
    chk("rst_buff_wr", bus.req_buff_wr, 0);
    chk("rst_buff_din", bus.sd_buff_din, 8'hFF);
    reset_n = 1'b1;
    tick();
    // host activity in IDLE is ignored
    chk("idle_req_ack", bus.req_ack, 0);
    chk("idle_buff_wr", bus.req_buff_wr, 0);
    chk("idle_busy", bus.busy, 0);
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    tick();

    // single read from drive 2
    set_lba(2, 32'h123);
    bus.req_rd[2] = 1'b1;
    tick();
    chk("sr_sd_rd", bus.sd_rd, 1);
    chk("sr_sd_wr", bus.sd_wr, 0);
    chk("sr_sd_lba", bus.sd_lba, 32'h123);
    chk("sr_busy", bus.busy, 1);
    tick();
    tick();
    tick();
    chk("sr_hold_rd", bus.sd_rd, 1);
    chk("sr_hold_lba", bus.sd_lba, 32'h123);
    chk("sr_no_ack", bus.req_ack, 0);
    tick();
    bus.sd_ack = 1'b1;
    #1;
    chk("sr_req_ack", bus.req_ack, 4'b0100);
    tick();
    chk("sr_rd_drop", bus.sd_rd, 0);
    bus.req_rd[2] = 1'b0;
    for (int s = 0; s < 512; s++) begin
      bus.sd_buff_wr = 1'b1;
      #1;
      chk("sr_buff_wr", bus.req_buff_wr, 4'b0100);
      tick();
      bus.sd_buff_wr = 1'b0;
      tick();
    end
    bus.sd_ack = 1'b0;
    #1;
    chk("sr_busy_at_fall", bus.busy, 1);
    tick();
    chk("sr_busy_after", bus.busy, 0);

    // round robin among rd0, rd1, wr3
    reset_dut();
    for (int i = 0; i < 4; i++) set_lba(i, 32'h1000 + i);
    bus.req_rd = 4'b0011;
    bus.req_wr = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!(bus.sd_rd || bus.sd_wr) && w < 10) begin
        tick();
        w++;
      end
      chk("rr_wait", (w < 10), 1);
      chk("rr_grant_lba", bus.sd_lba, 32'h1000 + rr_exp[k]);
      chk("rr_sd_wr", bus.sd_wr, (rr_exp[k] == 3));
      chk("rr_sd_rd", bus.sd_rd, (rr_exp[k] != 3));
      tick();
      tick();
      tick();
      bus.sd_ack = 1'b1;
      #1;
      chk("rr_req_ack", bus.req_ack, 4'(1) << rr_exp[k]);
      tick();
      bus.sd_ack = 1'b0;
      tick();
    end

    // write data mux
    reset_dut();
    set_din(1, 8'hA5);
    bus.req_wr[1] = 1'b1;
    tick();
    chk("wm_sd_wr", bus.sd_wr, 1);
    bus.sd_ack = 1'b1;
    #1;
    chk("wm_din_req", bus.sd_buff_din, 8'hA5);
    tick();
    chk("wm_din_xfer", bus.sd_buff_din, 8'hA5);
    bus.req_wr[1] = 1'b0;
    bus.sd_ack = 1'b0;
    tick();
    tick();
    chk("wm_din_idle", bus.sd_buff_din, 8'hFF);
    chk("wm_busy", bus.busy, 0);

    // withdraw without ack, drive 1 next
    reset_dut();
    set_lba(0, 32'hA0);
    set_lba(1, 32'hB1);
    bus.req_rd = 4'b0011;
    tick();
    chk("wd_sd_lba0", bus.sd_lba, 32'hA0);
    tick();
    tick();
    bus.req_rd[0] = 1'b0;
    tick();
    chk("wd_sd_rd", bus.sd_rd, 0);
    chk("wd_busy", bus.busy, 0);
    chk("wd_req_err", bus.req_err, 0);
    tick();
    chk("wd_next_rd", bus.sd_rd, 1);
    chk("wd_next_lba", bus.sd_lba, 32'hB1);

    // ack timeout on drive 3
    reset_dut();
    bus.req_rd[3] = 1'b1;
    tick();
    chk("to_sd_rd", bus.sd_rd, 1);
    for (int c = 0; c < 99; c++) begin
      tick();
      chk("to_no_err", bus.req_err, 0);
    end
    chk("to_rd_held", bus.sd_rd, 1);
    tick();
    chk("to_err", bus.req_err, 4'b1000);
    chk("to_sd_rd_drop", bus.sd_rd, 0);
    chk("to_busy", bus.busy, 0);
    bus.req_rd[3] = 1'b0;
    bus.sd_buff_wr = 1'b1;
    #1;
    chk("to_spurious_wr", bus.req_buff_wr, 0);
    tick();
    chk("to_err_pulse", bus.req_err, 0);
    chk("to_spurious_wr2", bus.req_buff_wr, 0);
    bus.sd_buff_wr = 1'b0;

    // async reset during XFER after moving the rotation pointer
    reset_dut();
    for (int i = 0; i < 4; i++) set_lba(i, 32'h2000 + i);
    bus.req_rd = 4'b0010;
    tick();
    bus.sd_ack = 1'b1;
    tick();
    bus.req_rd = 4'b0000;
    bus.sd_ack = 1'b0;
    tick();
    bus.req_wr = 4'b0100;
    tick();
    chk("ar_sd_wr", bus.sd_wr, 1);
    bus.sd_ack = 1'b1;
    tick();
    chk("ar_xfer_busy", bus.busy, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_sd_rd", bus.sd_rd, 0);
    chk("ar_sd_wr0", bus.sd_wr, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_req_ack", bus.req_ack, 0);
    bus.req_wr = 4'b0000;
    bus.sd_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req_rd = 4'b1010;
    tick();
    chk("ar_first_grant", bus.sd_lba, 32'h2001);

    // randomized transactions against a rotation-order model
    reset_dut();
    m_ptr = 0;
    for (int it = 0; it < 60; it++) begin
      rdv = 4'($urandom);
      wrv = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        m_lba[i] = $urandom;
        set_lba(i, m_lba[i]);
      end
      bus.req_rd = rdv;
      bus.req_wr = wrv;
      pend = rdv | wrv;
      if (pend == 4'b0000) begin
        tick();
        chk("rnd_idle_busy", bus.busy, 0);
        chk("rnd_idle_req", (bus.sd_rd | bus.sd_wr), 0);
        continue;
      end
      e = -1;
      for (int k = 0; k < 4; k++) begin
        if (e < 0 && pend[(m_ptr + k) % 4]) e = (m_ptr + k) % 4;
      end
      tick();
      chk("rnd_sd_rd", bus.sd_rd, rdv[e]);
      chk("rnd_sd_wr", bus.sd_wr, (!rdv[e] && wrv[e]));
      chk("rnd_sd_lba", bus.sd_lba, m_lba[e]);
      chk("rnd_busy", bus.busy, 1);
      w = $urandom_range(0, 3);
      for (int c = 0; c < w; c++) begin
        tick();
        chk("rnd_wait_ack", bus.req_ack, 0);
        chk("rnd_wait_lba", bus.sd_lba, m_lba[e]);
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.req_rd[e] = 1'b0;
        bus.req_wr[e] = 1'b0;
        tick();
        chk("rnd_wd_busy", bus.busy, 0);
        chk("rnd_wd_req", (bus.sd_rd | bus.sd_wr), 0);
        chk("rnd_wd_err", bus.req_err, 0);
        m_ptr = (e + 1) % 4;
        continue;
      end
      bus.sd_ack = 1'b1;
      #1;
      chk("rnd_req_ack", bus.req_ack, 4'(1) << e);
      tick();
      chk("rnd_ack_drop", (bus.sd_rd | bus.sd_wr), 0);
      w = $urandom_range(1, 6);
      for (int s = 0; s < w; s++) begin
        for (int i = 0; i < 4; i++) begin
          m_din[i] = 8'($urandom);
          set_din(i, m_din[i]);
        end
        bus.sd_buff_wr = 1'b1;
        #1;
        chk("rnd_buff_wr", bus.req_buff_wr, 4'(1) << e);
        chk("rnd_buff_din", bus.sd_buff_din, m_din[e]);
        tick();
        bus.sd_buff_wr = 1'b0;
      end
      bus.sd_ack = 1'b0;
      #1;
      chk("rnd_fall_busy", bus.busy, 1);
      tick();
      chk("rnd_end_busy", bus.busy, 0);
      chk("rnd_end_din", bus.sd_buff_din, 8'hFF);
      m_ptr = (e + 1) % 4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
